// File: rtl/athos_pkg.sv
// -----------------------------------------------------------------------------
// athos_pkg
// Shared definitions for the ATHOS SWAR bit-count pipeline.
//   - SWAR_MAX_W      : widest operand swar_mask() can describe.
//   - SWAR_STEP_MAX_W : width of the step count carried down the pipeline.
//   - swar_op_t       : per-operation control that travels alongside the data
//                       word (saturated step count and, when built, parity).
//   - swar_mask()     : returns M_k, the "f zeros above f ones" mask used by
//                       SWAR step k (f = 2^(k-1)).
// Optional feature macro: ATHOS_SWAR_PARITY_EN (adds the parity field).
// -----------------------------------------------------------------------------
package athos_pkg;

    localparam int SWAR_MAX_W      = 1024;
    // Four bits hold any LOG2W up to 15, far beyond SWAR_MAX_W's 10.
    localparam int SWAR_STEP_MAX_W = 4;

    // The data word itself is WIDTH-parametrised in each module, so it is
    // carried next to this struct; the struct holds everything else an
    // operation needs at each stage.
    typedef struct packed {
        logic [SWAR_STEP_MAX_W-1:0] steps;
`ifdef ATHOS_SWAR_PARITY_EN
        logic                       parity;
`endif
    } swar_op_t;

    // Bit i of M_k is set when bit i lies in the low half of its 2f-bit group,
    // i.e. when floor(i / f) is even. Bits at or above width are left clear.
    function automatic logic [SWAR_MAX_W-1:0] swar_mask(input int width, input int k);
        logic [SWAR_MAX_W-1:0] m;
        int                    f;
        m = '0;
        f = 1 << (k - 1);
        for (int i = 0; i < SWAR_MAX_W; i++) begin
            if ((i < width) && (((i / f) % 2) == 0)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage : athos_pkg

// File: rtl/swar_stage.sv
// -----------------------------------------------------------------------------
// swar_stage
// One SWAR pairwise-add step followed by its pipeline register.
// Stage K adds neighbouring f-bit fields (f = 2^(K-1)) into 2f-bit fields when
// the operation's step count is at least K, otherwise it passes data through.
// Parameters:
//   WIDTH : operand width (power of two, >= 8)
//   K     : step index, 1..LOG2W
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : global pipeline advance enable
//   i_valid      : valid bit of the incoming operation
//   i_data       : incoming partial result x_{K-1}
//   i_op         : incoming operation control (steps, optional parity)
//   o_valid      : registered valid bit
//   o_data       : registered x_K
//   o_op         : registered operation control
// Optional feature macro: ATHOS_SWAR_PARITY_EN (via athos_pkg::swar_op_t).
// -----------------------------------------------------------------------------
module swar_stage
    import athos_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  swar_op_t         i_op,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output swar_op_t         o_op
);

    localparam int                         F         = 1 << (K - 1);
    localparam logic [SWAR_MAX_W-1:0]      MASK_FULL = swar_mask(WIDTH, K);
    localparam logic [WIDTH-1:0]           MASK      = MASK_FULL[WIDTH-1:0];
    localparam logic [SWAR_STEP_MAX_W-1:0] K_STEP    = SWAR_STEP_MAX_W'(K);

    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_next;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    swar_op_t         r_op;

    // Each 2f-bit field sum is at most 2f, which fits in 2f bits, so a plain
    // WIDTH-bit add never carries across a field boundary.
    assign w_lo   = i_data & MASK;
    assign w_hi   = (i_data >> F) & MASK;
    assign w_sum  = w_lo + w_hi;
    assign w_next = (i_op.steps >= K_STEP) ? w_sum : i_data;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the pipeline shifts cleanly.
    // NOTE: data registers are cleared on reset as well as the valid bit,
    // because the last stage drives rd2_o/rd1_o, which must read 0 after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_op    <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_next;
            r_op    <= i_op;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_op    = r_op;

endmodule : swar_stage

// File: rtl/swar_popcount_pipe.sv
// -----------------------------------------------------------------------------
// swar_popcount_pipe
// Pipelined SWAR bit-count unit. LOG2W stages each apply one SWAR pairwise-add
// step; a per-operation step count picks how far the reduction goes (1 step =
// 2-bit pair sums, LOG2W steps = full popcount). An optional input byte swap
// handles big-endian word loads. Valid/ready handshake with backpressure via a
// single global enable that advances every stage together.
// Parameters:
//   WIDTH  : operand width, power of two, >= 8
//   LOG2W  : number of stages (derived)
//   STEP_W : width of steps_i (derived)
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   valid_i      : input operation valid
//   ready_o      : input accepted when valid_i && ready_o
//   rs1_i        : operand
//   steps_i      : SWAR steps to apply (0 = pass-through, >LOG2W saturates)
//   bswap_i      : reverse byte order of rs1_i before reduction
//   valid_o      : result valid
//   ready_i      : downstream accepts result when valid_o && ready_i
//   rd1_o        : parity of the conditioned operand (zero when not built)
//   rd2_o        : SWAR result
// Optional feature macro: ATHOS_SWAR_PARITY_EN (parity on rd1_o).
// -----------------------------------------------------------------------------
module swar_popcount_pipe
    import athos_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LOG2W  = $clog2(WIDTH),
    parameter int STEP_W = $clog2(LOG2W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  rs1_i,
    input  logic [STEP_W-1:0] steps_i,
    input  logic              bswap_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  rd1_o,
    output logic [WIDTH-1:0]  rd2_o
);

    localparam int                NBYTES   = WIDTH / 8;
    localparam logic [STEP_W-1:0] STEP_SAT = STEP_W'(LOG2W);

    logic [WIDTH-1:0]  w_x0;
    logic [STEP_W-1:0] w_steps_sat;
    swar_op_t          w_op0;
    logic              w_en;

    // Index 0 is the conditioned input; index k is the output of stage k.
    logic              w_valid [0:LOG2W];
    logic [WIDTH-1:0]  w_data  [0:LOG2W];
    swar_op_t          w_op    [0:LOG2W];

    // NOTE: every combinational output gets a default before any conditional
    // override, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_x0 = rs1_i;
        if (bswap_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                w_x0[8*b +: 8] = rs1_i[8*(NBYTES-1-b) +: 8];
            end
        end
    end

    assign w_steps_sat = (steps_i > STEP_SAT) ? STEP_SAT : steps_i;

    always_comb begin
        w_op0       = '0;
        w_op0.steps = SWAR_STEP_MAX_W'(w_steps_sat);
`ifdef ATHOS_SWAR_PARITY_EN
        w_op0.parity = ^w_x0;
`endif
    end

    // One enable for the whole pipeline: advance whenever the output slot is
    // empty or being drained. Bubbles move along with everything else.
    assign w_en = ready_i || !valid_o;

    // Reset forces ready high; inputs in that cycle are dropped because the
    // stage reset branch wins over the enable.
    assign ready_o = rst_i || w_en;

    assign w_valid[0] = valid_i;
    assign w_data[0]  = w_x0;
    assign w_op[0]    = w_op0;

    for (genvar k = 1; k <= LOG2W; k++) begin : g_stage
        swar_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_en    (w_en),
            .i_valid (w_valid[k-1]),
            .i_data  (w_data[k-1]),
            .i_op    (w_op[k-1]),
            .o_valid (w_valid[k]),
            .o_data  (w_data[k]),
            .o_op    (w_op[k])
        );
    end

    assign valid_o = w_valid[LOG2W];
    assign rd2_o   = w_data[LOG2W];

`ifdef ATHOS_SWAR_PARITY_EN
    assign rd1_o = {{(WIDTH-1){1'b0}}, w_op[LOG2W].parity};
`else
    assign rd1_o = '0;
`endif

    // The step count has no consumer past the final stage.
    logic w_unused_steps;
    assign w_unused_steps = ^w_op[LOG2W].steps;

endmodule : swar_popcount_pipe

// File: tb/tb_swar_popcount_pipe.sv
// -----------------------------------------------------------------------------
// tb_swar_popcount_pipe
// Directed bench for swar_popcount_pipe at WIDTH=32. Expected results are
// hand-computed constants. Inputs change 1 ns after the rising edge; outputs
// are sampled on the falling edge. The expected rd1_o follows whether
// ATHOS_SWAR_PARITY_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_swar_popcount_pipe;

    localparam int WIDTH  = 32;
    localparam int LOG2W  = 5;
    localparam int STEP_W = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              valid_i;
    logic              ready_o;
    logic [WIDTH-1:0]  rs1_i;
    logic [STEP_W-1:0] steps_i;
    logic              bswap_i;
    logic              valid_o;
    logic              ready_i;
    logic [WIDTH-1:0]  rd1_o;
    logic [WIDTH-1:0]  rd2_o;

    int n_total = 0;
    int n_bad   = 0;

    logic             mon_en = 1'b0;
    logic [WIDTH-1:0] mon_q [$];

    swar_popcount_pipe #(.WIDTH(WIDTH)) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .rs1_i   (rs1_i),
        .steps_i (steps_i),
        .bswap_i (bswap_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .rd1_o   (rd1_o),
        .rd2_o   (rd2_o)
    );

    always #5 clk_i = ~clk_i;

    // Records every completed output handshake while enabled.
    always @(negedge clk_i) begin
        if (mon_en && valid_o && ready_i) mon_q.push_back(rd2_o);
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd1(input logic par);
`ifdef ATHOS_SWAR_PARITY_EN
        return {{(WIDTH-1){1'b0}}, par};
`else
        return (par & 1'b0) ? '1 : '0;
`endif
    endfunction

    task automatic drive_idle();
        valid_i = 1'b0;
        rs1_i   = '0;
        steps_i = '0;
        bswap_i = 1'b0;
    endtask

    // Sends one op into an empty pipeline, measures edges from the accept
    // edge (counted as 1) until valid_o, then checks the result.
    task automatic run_single(input string tag, input logic [WIDTH-1:0] a, input int st,
                              input logic bs, input logic [WIDTH-1:0] exp2, input logic par);
        int lat;
        bit seen;
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        rs1_i   = a;
        steps_i = STEP_W'(st);
        bswap_i = bs;
        @(posedge clk_i); #1;
        drive_idle();
        seen = 1'b0;
        lat  = 1;
        while (!seen && lat <= 20) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
            else begin
                @(posedge clk_i);
                lat++;
            end
        end
        check({tag, "_lat"}, WIDTH'(lat), WIDTH'(LOG2W));
        check({tag, "_rd2"}, rd2_o, exp2);
        check({tag, "_rd1"}, rd1_o, exp_rd1(par));
        @(posedge clk_i); #1;
    endtask

    logic [WIDTH-1:0] s_in  [8] = '{32'h00000001, 32'h00000003, 32'h00000007, 32'h0000000F,
                                     32'h000000FF, 32'h0000FFFF, 32'h00FFFFFF, 32'hFFFFFFFF};
    logic [WIDTH-1:0] s_exp [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd16, 32'd24, 32'd32};

    initial begin
        rst_i   = 1'b1;
        ready_i = 1'b1;
        drive_idle();

        // Reset state, observed while reset is still asserted.
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        @(negedge clk_i);
        check("rst_valid", WIDTH'(valid_o), '0);
        check("rst_rd2", rd2_o, '0);
        check("rst_rd1", rd1_o, '0);
        check("rst_ready", WIDTH'(ready_o), WIDTH'(1));
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_ready", WIDTH'(ready_o), WIDTH'(1));

        // Directed single operations.
        run_single("pop_ones",  32'hFFFFFFFF, 5, 1'b0, 32'h00000020, 1'b0);
        run_single("pop_ends",  32'h80000001, 5, 1'b0, 32'h00000002, 1'b0);
        run_single("step1_ff",  32'hFFFFFFFF, 1, 1'b0, 32'hAAAAAAAA, 1'b0);
        run_single("step1_d",   32'h0000000D, 1, 1'b0, 32'h00000009, 1'b1);
        run_single("bswap_pt",  32'h12345678, 0, 1'b1, 32'h78563412, 1'b1);
        run_single("sat7",      32'h0000FFFF, 7, 1'b0, 32'h00000010, 1'b0);
        run_single("par7",      32'h00000007, 5, 1'b0, 32'h00000003, 1'b1);
        run_single("step2",     32'hF0F0F0F0, 2, 1'b0, 32'h40404040, 1'b0);
        run_single("step3",     32'h01030107, 3, 1'b0, 32'h01020103, 1'b1);
        run_single("step4",     32'hFFFF0001, 4, 1'b0, 32'h00100001, 1'b1);
        run_single("pass",      32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 1'b0);
        run_single("bswap_pop", 32'h000000FF, 5, 1'b1, 32'h00000008, 1'b0);
        run_single("sat6",      32'hFFFFFFFF, 6, 1'b1, 32'h00000020, 1'b0);
        run_single("zero",      32'h00000000, 5, 1'b0, 32'h00000000, 1'b0);

        // Backpressure: 8 back-to-back ops, then stall with the pipeline full.
        mon_q.delete();
        mon_en = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            rs1_i   = s_in[i];
            steps_i = 3'd5;
            bswap_i = 1'b0;
            @(posedge clk_i); #1;
        end
        drive_idle();
        ready_i = 1'b0;
        // Ops 0..2 have drained; op 3 sits at the output.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check($sformatf("stall%0d_valid", c), WIDTH'(valid_o), WIDTH'(1));
            check($sformatf("stall%0d_ready", c), WIDTH'(ready_o), '0);
            check($sformatf("stall%0d_rd2", c), rd2_o, 32'd4);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        repeat (12) @(posedge clk_i);
        #1;
        check("bp_count", WIDTH'(mon_q.size()), WIDTH'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < mon_q.size()) check($sformatf("bp_res%0d", i), mon_q[i], s_exp[i]);
            else check($sformatf("bp_res%0d_missing", i), '1, s_exp[i]);
        end

        // Reset with 3 ops in flight; an input offered during reset is dropped.
        mon_q.delete();
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            rs1_i   = s_in[i];
            steps_i = 3'd5;
            @(posedge clk_i); #1;
        end
        rst_i   = 1'b1;
        valid_i = 1'b1;
        rs1_i   = 32'h000000FF;
        @(negedge clk_i);
        check("midrst_ready_during", WIDTH'(ready_o), WIDTH'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive_idle();
        @(negedge clk_i);
        check("midrst_valid", WIDTH'(valid_o), '0);
        check("midrst_rd2", rd2_o, '0);
        check("midrst_ready", WIDTH'(ready_o), WIDTH'(1));
        repeat (12) @(posedge clk_i);
        #1;
        check("midrst_no_stale", WIDTH'(mon_q.size()), '0);
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_swar_popcount_pipe
